// File: rtl/mem_arbiter_if.sv
// Signal bundle for mem_arbiter: fetch port, data port, shared memory port and status.
// master = arbiter side, slave = requesters/memory side.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_o;
  logic        err_o;

  modport master (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
           mem_ack_i,
    output if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o, mem_req_o, mem_we_o, mem_addr_o,
           mem_wdata_o, stall_o, err_o
  );

  modport slave (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
           mem_ack_i,
    input  if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o, mem_req_o, mem_we_o, mem_addr_o,
           mem_wdata_o, stall_o, err_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one single-port memory.
// Define MEM_ARB_TIMEOUT_EN to build in the BUSY watchdog and sticky err_o.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm, StResp} state_e;

  state_e      state_q;
  logic        last_dm_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        if_ack_q;
  logic        dm_ack_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;

  logic        busy;
  logic        grant_dm;
  logic        timeout;
  logic [31:0] resp_data;

  assign busy      = (state_q == StBusyIf) || (state_q == StBusyDm);
  // DM wins unless IF is also waiting and DM had the previous grant.
  assign grant_dm  = bus.dm_req_i & ~(bus.if_req_i & last_dm_q);
  assign resp_data = bus.mem_ack_i ? bus.mem_rdata_i : 32'h0;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CntW-1:0] wdog_q;
  logic            err_q;

  // Fires during the BUSY cycle that would bring the count to TIMEOUT.
  assign timeout = busy && (wdog_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else if (!busy) begin
      wdog_q <= '0;
    end else if (!bus.mem_ack_i) begin
      wdog_q <= wdog_q + CntW'(1);
      if (timeout) err_q <= 1'b1;
    end
  end

  assign bus.err_o = err_q;
`else
  assign timeout   = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      last_dm_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      dm_rdata_q  <= 32'h0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_dm) begin
            state_q     <= StBusyDm;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dm_we_i;
            mem_addr_q  <= bus.dm_addr_i;
            mem_wdata_q <= bus.dm_wdata_i;
          end else if (bus.if_req_i) begin
            state_q     <= StBusyIf;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr_i;
            mem_wdata_q <= 32'h0;
          end
        end
        StBusyIf, StBusyDm: begin
          if (bus.mem_ack_i || timeout) begin
            state_q   <= StResp;
            mem_req_q <= 1'b0;
            last_dm_q <= (state_q == StBusyDm);
            if (state_q == StBusyDm) begin
              dm_ack_q   <= 1'b1;
              dm_rdata_q <= resp_data;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= resp_data;
            end
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.dm_ack_o    = dm_ack_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  // Gated by reset so every output reads 0 while reset is held.
  assign bus.stall_o = rst_n_i & ((bus.if_req_i & ~if_ack_q) | (bus.dm_req_i & ~dm_ack_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of grant order and memory contents.
module tb_mem_arbiter;
  localparam int unsigned TbTimeout = 4;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(TbTimeout)) dut (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  bit resp_en    = 1'b1;
  bit mem_never  = 1'b0;
  bit rand_delay = 1'b0;
  int mem_delay  = 1;
  int busy_n     = 0;
  int cur_delay  = 1;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Memory responder: acks in the cur_delay-th BUSY cycle, garbage data otherwise.
  always begin
    @(posedge clk_i);
    #1;
    if (resp_en) begin
      if (bus.mem_req_o) begin
        if (busy_n == 0) cur_delay = rand_delay ? int'($urandom_range(1, 4)) : mem_delay;
        busy_n++;
        if (!mem_never && busy_n == cur_delay) begin
          bus.mem_ack_i = 1'b1;
          if (bus.mem_we_o) begin
            mem_arr[bus.mem_addr_o] = bus.mem_wdata_o;
            bus.mem_rdata_i = 32'h0;
          end else begin
            bus.mem_rdata_i = mem_arr.exists(bus.mem_addr_o) ? mem_arr[bus.mem_addr_o]
                                                              : init_val(bus.mem_addr_o);
          end
        end else begin
          bus.mem_ack_i   = 1'b0;
          bus.mem_rdata_i = $urandom;
        end
      end else begin
        busy_n        = 0;
        bus.mem_ack_i = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = 32'h0;
    bus.dm_req_i   = 1'b0;
    bus.dm_we_i    = 1'b0;
    bus.dm_addr_i  = 32'h0;
    bus.dm_wdata_i = 32'h0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    clear_inputs();
    resp_en    = 1'b1;
    mem_never  = 1'b0;
    rand_delay = 1'b0;
    mem_delay  = 1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i        = 1'b0;
    bus.mem_ack_i  = 1'b0;
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = 32'h20;
    bus.dm_req_i   = 1'b1;
    bus.dm_we_i    = 1'b1;
    bus.dm_addr_i  = 32'h30;
    bus.dm_wdata_i = 32'hCAFE_F00D;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.if_ack_o, bus.dm_ack_o, bus.stall_o, bus.err_o}
        !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {bus.mem_req_o, bus.mem_we_o,
               bus.if_ack_o, bus.dm_ack_o, bus.stall_o, bus.err_o});
    end
    checks++;
    if ({bus.mem_addr_o, bus.mem_wdata_o, bus.if_rdata_o, bus.dm_rdata_o} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h want all 0", bus.mem_addr_o, bus.mem_wdata_o,
               bus.if_rdata_o, bus.dm_rdata_o);
    end
    // Only IF left pending: it must be granted on the first edge after release.
    bus.dm_req_i = 1'b0;
    rst_n_i      = 1'b1;
    tick();
    checks++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h20) begin
      errors++;
      $display("FAIL reset_first_grant: got req=%b addr=%h want req=1 addr=00000020",
               bus.mem_req_o, bus.mem_addr_o);
    end
    tick();
    checks++;
    if (bus.if_ack_o !== 1'b1 || bus.if_rdata_o !== init_val(32'h20)) begin
      errors++;
      $display("FAIL reset_first_ack: got ack=%b data=%h want ack=1 data=%h", bus.if_ack_o,
               bus.if_rdata_o, init_val(32'h20));
    end
    bus.if_req_i = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    do_reset();
    mem_arr[32'h10] = 32'h00A0_0093;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h10;
    tick();
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.if_ack_o, bus.stall_o} !== 4'b1001 ||
        bus.mem_addr_o !== 32'h10) begin
      errors++;
      $display("FAIL fetch_busy: got req/we/ack/stall=%b addr=%h want 1001 addr=00000010",
               {bus.mem_req_o, bus.mem_we_o, bus.if_ack_o, bus.stall_o}, bus.mem_addr_o);
    end
    tick();
    checks++;
    if ({bus.if_ack_o, bus.dm_ack_o, bus.mem_req_o, bus.stall_o} !== 4'b1000 ||
        bus.if_rdata_o !== 32'h00A0_0093) begin
      errors++;
      $display("FAIL fetch_resp: got ack/dmack/req/stall=%b data=%h want 1000 data=00a00093",
               {bus.if_ack_o, bus.dm_ack_o, bus.mem_req_o, bus.stall_o}, bus.if_rdata_o);
    end
    bus.if_req_i = 1'b0;
    tick();
    checks++;
    if (bus.if_ack_o !== 1'b0 || bus.if_rdata_o !== 32'h00A0_0093) begin
      errors++;
      $display("FAIL fetch_hold: got ack=%b data=%h want ack=0 data=00a00093", bus.if_ack_o,
               bus.if_rdata_o);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = 32'h4;
    bus.dm_req_i   = 1'b1;
    bus.dm_we_i    = 1'b1;
    bus.dm_addr_i  = 32'h100;
    bus.dm_wdata_i = 32'hDEAD_BEEF;
    tick();
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.stall_o} !== 3'b111 || bus.mem_addr_o !== 32'h100 ||
        bus.mem_wdata_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL simul_dm_grant: got req/we/stall=%b addr=%h wdata=%h want 111 100 deadbeef",
               {bus.mem_req_o, bus.mem_we_o, bus.stall_o}, bus.mem_addr_o, bus.mem_wdata_o);
    end
    tick();
    checks++;
    if ({bus.dm_ack_o, bus.if_ack_o, bus.stall_o} !== 3'b101) begin
      errors++;
      $display("FAIL simul_dm_ack: got dmack/ifack/stall=%b want 101",
               {bus.dm_ack_o, bus.if_ack_o, bus.stall_o});
    end
    bus.dm_req_i = 1'b0;
    tick();
    checks++;
    if ({bus.mem_req_o, bus.dm_ack_o, bus.stall_o} !== 3'b001) begin
      errors++;
      $display("FAIL simul_idle: got req/dmack/stall=%b want 001",
               {bus.mem_req_o, bus.dm_ack_o, bus.stall_o});
    end
    tick();
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.stall_o} !== 3'b101 || bus.mem_addr_o !== 32'h4) begin
      errors++;
      $display("FAIL simul_if_grant: got req/we/stall=%b addr=%h want 101 addr=00000004",
               {bus.mem_req_o, bus.mem_we_o, bus.stall_o}, bus.mem_addr_o);
    end
    tick();
    checks++;
    if ({bus.if_ack_o, bus.stall_o} !== 2'b10 || bus.if_rdata_o !== init_val(32'h4)) begin
      errors++;
      $display("FAIL simul_if_ack: got ack/stall=%b data=%h want 10 data=%h",
               {bus.if_ack_o, bus.stall_o}, bus.if_rdata_o, init_val(32'h4));
    end
    bus.if_req_i = 1'b0;
    tick();
    checks++;
    if (!mem_arr.exists(32'h100) || mem_arr[32'h100] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL simul_write: memory at 00000100 not written with deadbeef");
    end
  endtask

  task automatic test_fairness();
    logic [31:0] g [3];
    logic [31:0] exp_g [3];
    int n = 0;
    bit both = 1'b0;
    logic prev = 1'b0;
    exp_g[0] = 32'h200;
    exp_g[1] = 32'h300;
    exp_g[2] = 32'h200;
    do_reset();
    bus.dm_req_i  = 1'b1;
    bus.dm_addr_i = 32'h200;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h300;
    for (int i = 0; i < 40 && n < 3; i++) begin
      tick();
      if (bus.if_ack_o && bus.dm_ack_o) both = 1'b1;
      if (bus.mem_req_o && !prev) begin
        g[n] = bus.mem_addr_o;
        n++;
      end
      prev = bus.mem_req_o;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL fair_count: got %0d grants want 3", n);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k < n && g[k] !== exp_g[k]) begin
        errors++;
        $display("FAIL fair_order[%0d]: got addr %h want %h", k, g[k], exp_g[k]);
      end
    end
    checks++;
    if (both) begin
      errors++;
      $display("FAIL fair_dual_ack: got both acks in one cycle want never");
    end
    clear_inputs();
    repeat (4) tick();
  endtask

  task automatic test_slow_memory();
    logic [31:0] a;
    int  cnt = 0;
    bit  moved = 1'b0;
    bit  got = 1'b0;
    do_reset();
    mem_delay     = 5;
    a             = 32'h800 + {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    bus.dm_req_i  = 1'b1;
    bus.dm_we_i   = 1'b0;
    bus.dm_addr_i = a;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus.mem_req_o) begin
        cnt++;
        if (bus.mem_addr_o !== a) moved = 1'b1;
      end
      if (bus.dm_ack_o) got = 1'b1;
    end
    checks++;
    if (cnt != 5 || moved) begin
      errors++;
      $display("FAIL slow_busy: got %0d req cycles moved=%0b want 5 cycles stable", cnt, moved);
    end
    checks++;
    if (!got || bus.dm_rdata_o !== init_val(a)) begin
      errors++;
      $display("FAIL slow_ack: got ack=%0b data=%h want ack=1 data=%h", got, bus.dm_rdata_o,
               init_val(a));
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_abort_ignored();
    bit got = 1'b0;
    do_reset();
    mem_delay     = 3;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h44;
    tick();
    bus.if_req_i = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (bus.if_ack_o) got = 1'b1;
    end
    checks++;
    if (!got || bus.if_rdata_o !== init_val(32'h44)) begin
      errors++;
      $display("FAIL abort_ack: got ack=%0b data=%h want ack=1 data=%h", got, bus.if_rdata_o,
               init_val(32'h44));
    end
    tick();
  endtask

  task automatic test_spurious_ack();
    bit bad = 1'b0;
    do_reset();
    resp_en         = 1'b0;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h1234_5678;
    repeat (4) begin
      tick();
      if (bus.if_ack_o || bus.dm_ack_o || bus.mem_req_o) bad = 1'b1;
    end
    bus.mem_ack_i = 1'b0;
    resp_en       = 1'b1;
    checks++;
    if (bad || bus.if_rdata_o !== 32'h0 || bus.dm_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL spurious_ack: got activity=%0b rdata=%h/%h want 0 0/0", bad,
               bus.if_rdata_o, bus.dm_rdata_o);
    end
  endtask

  task automatic test_reset_mid();
    bit bad = 1'b0;
    bit got = 1'b0;
    do_reset();
    mem_never      = 1'b1;
    bus.dm_req_i   = 1'b1;
    bus.dm_we_i    = 1'b1;
    bus.dm_addr_i  = 32'h180;
    bus.dm_wdata_i = $urandom;
    tick();
    tick();
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o} !== 2'b11) begin
      errors++;
      $display("FAIL rmid_busy: got req/we=%b want 11", {bus.mem_req_o, bus.mem_we_o});
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.if_ack_o, bus.dm_ack_o, bus.stall_o, bus.err_o}
        !== 6'b0 || {bus.mem_addr_o, bus.mem_wdata_o} !== 64'h0) begin
      errors++;
      $display("FAIL rmid_clear: got ctrl=%b addr=%h wdata=%h want all 0", {bus.mem_req_o,
               bus.mem_we_o, bus.if_ack_o, bus.dm_ack_o, bus.stall_o, bus.err_o},
               bus.mem_addr_o, bus.mem_wdata_o);
    end
    @(posedge clk_i);
    #1;
    rst_n_i      = 1'b1;
    bus.dm_req_i = 1'b0;
    mem_never    = 1'b0;
    repeat (6) begin
      tick();
      if (bus.dm_ack_o || bus.if_ack_o || bus.mem_req_o) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rmid_no_ack: got activity after release want none");
    end
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h1C0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (bus.if_ack_o) got = 1'b1;
    end
    checks++;
    if (!got || bus.if_rdata_o !== init_val(32'h1C0)) begin
      errors++;
      $display("FAIL rmid_recover: got ack=%0b data=%h want ack=1 data=%h", got,
               bus.if_rdata_o, init_val(32'h1C0));
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_watchdog();
    int  cnt = 0;
    bit  got = 1'b0;
    do_reset();
    mem_never     = 1'b1;
    bus.dm_req_i  = 1'b1;
    bus.dm_addr_i = 32'h1E0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus.mem_req_o) cnt++;
      if (bus.dm_ack_o) got = 1'b1;
    end
    checks++;
    if (!got || cnt != int'(TbTimeout) || bus.dm_rdata_o !== 32'h0 || bus.err_o !== 1'b1) begin
      errors++;
      $display("FAIL wdog_fire: got ack=%0b busy=%0d data=%h err=%b want 1 %0d 0 1", got, cnt,
               bus.dm_rdata_o, bus.err_o, TbTimeout);
    end
    bus.dm_req_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.err_o !== 1'b1) begin
      errors++;
      $display("FAIL wdog_sticky: got err=%b want 1", bus.err_o);
    end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.mem_req_o) cnt++;
      if (bus.dm_ack_o || bus.err_o) got = 1'b1;
    end
    checks++;
    if (cnt != 20 || got) begin
      errors++;
      $display("FAIL wdog_off: got busy=%0d ack_or_err=%0b want 20 0", cnt, got);
    end
`endif
    do_reset();
    checks++;
    if (bus.err_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL wdog_reset: got err=%b req=%b want 0 0", bus.err_o, bus.mem_req_o);
    end
  endtask

  task automatic test_random();
    logic        if_pend = 1'b0;
    logic        dm_pend = 1'b0;
    logic [31:0] if_a = 32'h0;
    logic [31:0] dm_a = 32'h0;
    logic [31:0] dm_wd = 32'h0;
    logic        dm_w = 1'b0;
    logic        in_flight = 1'b0;
    logic        cur_dm = 1'b0;
    logic        last_dm = 1'b0;
    logic        prev_req = 1'b0;
    logic        exp_dm;
    logic [31:0] exp_addr;
    logic [31:0] exp_d;
    int          done = 0;
    int          cyc = 0;
    do_reset();
    rand_delay = 1'b1;
    while (done < 80 && cyc < 4000) begin
      tick();
      cyc++;
      if (bus.mem_req_o && !prev_req) begin
        exp_dm   = dm_pend && !(if_pend && last_dm);
        exp_addr = exp_dm ? dm_a : if_a;
        checks++;
        if (in_flight || !(if_pend || dm_pend) || bus.mem_addr_o !== exp_addr ||
            bus.mem_we_o !== (exp_dm && dm_w) || (exp_dm && dm_w && bus.mem_wdata_o !== dm_wd))
        begin
          errors++;
          $display("FAIL rand_grant: got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                   bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o, exp_addr, exp_dm && dm_w,
                   dm_wd);
        end
        in_flight = 1'b1;
        cur_dm    = exp_dm;
      end
      prev_req = bus.mem_req_o;
      if (bus.if_ack_o || bus.dm_ack_o) begin
        checks++;
        if (!in_flight || bus.dm_ack_o !== cur_dm || bus.if_ack_o !== !cur_dm) begin
          errors++;
          $display("FAIL rand_ack_who: got if=%b dm=%b want dm=%b in_flight=%b", bus.if_ack_o,
                   bus.dm_ack_o, cur_dm, in_flight);
        end
        checks++;
        if (cur_dm) begin
          exp_d = dm_w ? 32'h0 : ref_read(dm_a);
          if (bus.dm_rdata_o !== exp_d) begin
            errors++;
            $display("FAIL rand_dm_data: got %h want %h addr=%h", bus.dm_rdata_o, exp_d, dm_a);
          end
          if (dm_w) ref_mem[dm_a] = dm_wd;
          dm_pend = 1'b0;
        end else begin
          exp_d = ref_read(if_a);
          if (bus.if_rdata_o !== exp_d) begin
            errors++;
            $display("FAIL rand_if_data: got %h want %h addr=%h", bus.if_rdata_o, exp_d, if_a);
          end
          if_pend = 1'b0;
        end
        last_dm   = cur_dm;
        in_flight = 1'b0;
        done++;
      end
      if (done < 80) begin
        if (!if_pend && $urandom_range(0, 2) == 0) begin
          if_pend = 1'b1;
          if_a    = 32'h400 + 32'($urandom_range(0, 7)) * 32'd4;
        end
        if (!dm_pend && $urandom_range(0, 2) == 0) begin
          dm_pend = 1'b1;
          dm_a    = 32'h400 + 32'($urandom_range(0, 7)) * 32'd4;
          dm_w    = 1'($urandom_range(0, 1));
          dm_wd   = $urandom;
        end
      end
      bus.if_req_i   = if_pend;
      bus.if_addr_i  = if_a;
      bus.dm_req_i   = dm_pend;
      bus.dm_we_i    = dm_w;
      bus.dm_addr_i  = dm_a;
      bus.dm_wdata_i = dm_wd;
    end
    checks++;
    if (done < 80) begin
      errors++;
      $display("FAIL rand_progress: got %0d completions in %0d cycles want 80", done, cyc);
    end
    clear_inputs();
    repeat (3) tick();
  endtask

  initial begin
    clear_inputs();
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'h0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_fairness();
    test_slow_memory();
    test_abort_ignored();
    test_spurious_ack();
    test_reset_mid();
    test_watchdog();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum BUSY cycles allowed without mem_ack_i (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 if_req_i  input  1  instruction-fetch read request, held until if_ack_o.
REQ-005 if_addr_i  input  32  fetch address.
REQ-006 if_ack_o  output  1  one-cycle fetch completion pulse.
REQ-007 if_rdata_o  output  32  fetch data, valid while if_ack_o=1.
REQ-008 dm_req_i  input  1  data-memory request, held until dm_ack_o.
REQ-009 dm_we_i  input  1  1=write, 0=read.
REQ-010 dm_addr_i  input  32  data address.
REQ-011 dm_wdata_i  input  32  write data.
REQ-012 dm_ack_o  output  1  one-cycle data completion pulse.
REQ-013 dm_rdata_o  output  32  read data, valid while dm_ack_o=1.
REQ-014 mem_req_o  output  1  request to the shared single-port memory.
REQ-015 mem_we_o  output  1  write enable to memory.
REQ-016 mem_addr_o  output  32  memory address.
REQ-017 mem_wdata_o  output  32  memory write data.
REQ-018 mem_rdata_i  input  32  memory read data, valid with mem_ack_i.
REQ-019 mem_ack_i  input  1  memory completion, single cycle.
REQ-020 stall_o  output  1  pipeline stall (PC and pipeline-register write inhibit).
REQ-021 err_o  output  1  sticky timeout flag.

Function
REQ-022 FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
REQ-023 IDLE with dm_req_i=1: go to BUSY_DM, unless if_req_i=1 and the last completed grant was DM, in which case go to BUSY_IF.
REQ-024 IDLE with only if_req_i=1: go to BUSY_IF; with no request: stay in IDLE.
REQ-025 On the grant edge, register mem_addr_o, mem_we_o (0 for IF), and mem_wdata_o from the winner; hold them stable throughout BUSY.
REQ-026 mem_req_o SHALL be 1 exactly while in BUSY_IF or BUSY_DM.
REQ-027 BUSY with mem_ack_i=1: capture mem_rdata_i, go to RESP.
REQ-028 RESP: pulse the granted requester's ack for exactly one cycle with the captured data, record the last grant, return to IDLE; mem_req_o=0.
REQ-029 Minimum latency from request to ack is 3 cycles when memory acks in its first BUSY cycle (request seen at N, BUSY at N+1, RESP at N+2).
REQ-030 stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational.
REQ-031 A requester deasserting its request mid-transaction SHALL NOT abort the transaction; the ack still pulses and is ignored.
REQ-032 mem_ack_i outside BUSY SHALL be ignored.
REQ-033 if_rdata_o and dm_rdata_o SHALL hold their last value when not acked.
REQ-034 if_ack_o and dm_ack_o SHALL never be 1 in the same cycle.

Reset
REQ-035 rst_n_i=0 SHALL immediately force IDLE, last grant = IF, all outputs 0, and err_o cleared, including mid-transaction.
REQ-036 The first arbitration after reset release SHALL occur on the first rising edge with rst_n_i=1.

Configuration
REQ-037 The macro MEM_ARB_TIMEOUT_EN SHALL compile in an 8-bit-minimum watchdog counter that clears on BUSY entry and increments each BUSY cycle without mem_ack_i.
REQ-038 With MEM_ARB_TIMEOUT_EN, when the counter reaches TIMEOUT the FSM SHALL enter RESP with captured data 0x00000000 and set err_o until reset.
REQ-039 Without MEM_ARB_TIMEOUT_EN, BUSY SHALL wait indefinitely and err_o SHALL be tied to 0.

Verification
REQ-040 Single fetch: if_req_i=1 with if_addr_i=0x00000010, memory acks in its first BUSY cycle with 0x00A00093 -> mem_addr_o=0x10, if_ack_o at cycle N+2, if_rdata_o=0x00A00093.
REQ-041 Simultaneous requests after reset: IF read at 0x4 and DM write of 0xDEADBEEF to 0x100 -> DM granted first (mem_we_o=1, mem_wdata_o=0xDEADBEEF), then IF; stall_o=1 until the IF ack.
REQ-042 Fairness: DM request held continuously and IF request pending -> grants alternate DM, IF, DM.
REQ-043 Slow memory: mem_ack_i delayed 5 cycles -> mem_addr_o stable throughout, mem_req_o=1 for exactly 5 cycles, then the ack pulse.
REQ-044 Reset pulse during BUSY_DM -> all outputs 0 immediately and no ack after release; a subsequent request completes normally.
REQ-045 With MEM_ARB_TIMEOUT_EN, TIMEOUT=4, and memory never acking -> ack pulse with data 0 after 4 BUSY cycles, err_o=1 until reset.
